// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the elastic pipeline-stage buffer.
package pipe_pkg;

   localparam int   PERF_CNT_W   = 32;
   localparam logic FLUSH_ACTIVE = 1'b1;

   // Pointer increment with explicit wrap so non-power-of-2 depths work.
   function automatic logic [31:0] next_ptr(input logic [31:0] ptr, input logic [31:0] depth);
      return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
   endfunction

endpackage

// File: rtl/pipe_stage_buf.sv
// DEPTH-entry elastic pipeline stage with valid/ready handshake, synchronous flush
// and registered-only ready. Optional perf counters via PIPE_STAGE_BUF_PERF_EN.
module pipe_stage_buf
   import pipe_pkg::*;
#(
   parameter int  WIDTH = 32,
   parameter int  DEPTH = 2,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [CNT_W-1:0] count
`ifdef PIPE_STAGE_BUF_PERF_EN
   ,
   output logic [PERF_CNT_W-1:0] stall_cnt,
   output logic [PERF_CNT_W-1:0] full_cnt
`endif
);

   localparam int               PTR_W    = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             push;
   logic             pop;
   logic             flush_hit;

   assign flush_hit = (flush == FLUSH_ACTIVE);
   assign in_ready  = (count < FULL_CNT);
   assign out_valid = (count != '0);
   assign out_data  = out_valid ? mem[rd_ptr] : '0;
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   // Storage needs no reset; only slots covered by count are ever observed.
   always_ff @(posedge clk) begin
      if (push && !flush_hit) begin
         mem[wr_ptr] <= in_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush_hit) begin
         count  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            wr_ptr <= PTR_W'(next_ptr(32'(wr_ptr), 32'(DEPTH)));
         end
         if (pop) begin
            rd_ptr <= PTR_W'(next_ptr(32'(rd_ptr), 32'(DEPTH)));
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

`ifdef PIPE_STAGE_BUF_PERF_EN
   // Saturating event counters; flush deliberately leaves them alone.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
         full_cnt  <= '0;
      end else begin
         if (out_valid && !out_ready && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + PERF_CNT_W'(1);
         end
         if (in_valid && !in_ready && full_cnt != '1) begin
            full_cnt <= full_cnt + PERF_CNT_W'(1);
         end
      end
   end
`endif

   a_count_bound : assert property (@(posedge clk) disable iff (rst) count <= FULL_CNT);

   a_hold_stable : assert property (@(posedge clk) disable iff (rst)
      (out_valid && !out_ready && !flush_hit) |=> $stable(out_data));

endmodule
